alu_mdu: RTL and testbench

Parametrised multiply/divide unit that extends the combinational execute-stage ALU with iterative MIPS MULT/MULTU/DIV/DIVU and architectural HI/LO registers. It sits beside the ALU in EX and accepts one operation through a valid/ready handshake. While an operation is in flight it asserts `m_o_busy`, which the hazard unit uses to stall the pipeline. Results are read through `m_o_hi`/`m_o_lo` (MFHI/MFLO).

---
 rtl/alu_mdu_if.sv | 26 ++
 rtl/alu_mdu.sv | 182 ++++++++++++++++++
 tb/tb_alu_mdu.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_if.sv
// Handshake bundle between the EX stage and the multiply/divide unit.
// The master issues operations; the slave (alu_mdu) returns status and HI/LO.
interface alu_mdu_if #(
  parameter int DWIDTH = 32
);
  logic              m_i_valid;
  logic [2:0]        m_i_op;
  logic [DWIDTH-1:0] m_i_rs;
  logic [DWIDTH-1:0] m_i_rt;
  logic              m_i_flush;
  logic              m_o_ready;
  logic              m_o_busy;
  logic              m_o_done;
  logic [DWIDTH-1:0] m_o_hi;
  logic [DWIDTH-1:0] m_o_lo;

  modport master (
    output m_i_valid, m_i_op, m_i_rs, m_i_rt, m_i_flush,
    input  m_o_ready, m_o_busy, m_o_done, m_o_hi, m_o_lo
  );

  modport slave (
    input  m_i_valid, m_i_op, m_i_rs, m_i_rt, m_i_flush,
    output m_o_ready, m_o_busy, m_o_done, m_o_hi, m_o_lo
  );
endinterface

// File: rtl/alu_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide share one 2*DWIDTH+1 accumulator.
module alu_mdu #(
  parameter int DWIDTH = 32,
  parameter int CWIDTH = $clog2(DWIDTH) + 1
) (
  input logic      clk,
  input logic      rst,
  alu_mdu_if.slave m
);
  localparam int AW = 2 * DWIDTH + 1;

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic [1:0]        op_q, op_d;
  logic [DWIDTH-1:0] rs_q, rs_d;
  logic [DWIDTH-1:0] rt_q, rt_d;
  logic [DWIDTH-1:0] opd_q, opd_d;
  logic [DWIDTH-1:0] hi_q, hi_d;
  logic [DWIDTH-1:0] lo_q, lo_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic              sgn_q, sgn_d;
  logic              rsg_q, rsg_d;
  logic              done_q, done_d;

  logic                accept;
  logic                is_div;
  logic                sgn_op;
  logic                neg_a;
  logic                neg_b;
  logic [DWIDTH-1:0]   mag_a;
  logic [DWIDTH-1:0]   mag_b;
  logic [DWIDTH-1:0]   quo;
  logic [DWIDTH-1:0]   rem;
  logic [DWIDTH:0]     msum;
  logic [DWIDTH:0]     dtop;
  logic [DWIDTH:0]     ddiff;
  logic [AW-1:0]       mnext;
  logic [AW-1:0]       dsh;
  logic [AW-1:0]       dnext;
  logic [2*DWIDTH-1:0] prod;

  assign m.m_o_ready = (state_q == IDLE) && !pend_q;
  assign m.m_o_busy  = (state_q != IDLE);
  assign m.m_o_done  = done_q;
  assign m.m_o_hi    = hi_q;
  assign m.m_o_lo    = lo_q;

  assign accept = m.m_i_valid && m.m_o_ready && !m.m_i_flush;

  always_comb begin
    is_div = op_q[1];
    sgn_op = ~op_q[0];
    neg_a  = sgn_op & rs_q[DWIDTH-1];
    neg_b  = sgn_op & rt_q[DWIDTH-1];
    mag_a  = neg_a ? -rs_q : rs_q;
    mag_b  = neg_b ? -rt_q : rt_q;
    // Multiply: add multiplicand into the upper half, then shift right
    msum   = acc_q[AW-1:DWIDTH] + {1'b0, opd_q};
    mnext  = acc_q[0] ? ({msum, acc_q[DWIDTH-1:0]} >> 1)
                      : (acc_q >> 1);
    // Divide: shift left, trial-subtract divisor, set quotient bit
    dsh    = {acc_q[AW-2:0], 1'b0};
    dtop   = dsh[AW-1:DWIDTH];
    ddiff  = dtop - {1'b0, opd_q};
    dnext  = (dtop >= {1'b0, opd_q})
           ? {ddiff, dsh[DWIDTH-1:1], 1'b1}
           : dsh;
    prod   = sgn_q ? -acc_q[2*DWIDTH-1:0]
                   : acc_q[2*DWIDTH-1:0];
    quo    = sgn_q ? -acc_q[DWIDTH-1:0]
                   : acc_q[DWIDTH-1:0];
    rem    = rsg_q ? -acc_q[2*DWIDTH-1:DWIDTH]
                   : acc_q[2*DWIDTH-1:DWIDTH];
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    opd_d   = opd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    rsg_d   = rsg_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (!m.m_i_flush) state_d = PREP;
        end else if (accept) begin
          op_d = m.m_i_op[1:0];
          rs_d = m.m_i_rs;
          rt_d = m.m_i_rt;
          unique case (1'b1)
            (m.m_i_op == 3'd4): hi_d   = m.m_i_rs;
            (m.m_i_op == 3'd5): lo_d   = m.m_i_rs;
            (!m.m_i_op[2]):     pend_d = 1'b1;
            default: ;
          endcase
        end
      end
      PREP: begin
        sgn_d   = neg_a ^ neg_b;
        rsg_d   = neg_a;
        cnt_d   = '0;
        opd_d   = is_div ? mag_b : mag_a;
        acc_d   = {{(DWIDTH+1){1'b0}}, is_div ? mag_a : mag_b};
        state_d = RUN;
      end
      RUN: begin
        acc_d = is_div ? dnext : mnext;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CWIDTH'(DWIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (!is_div) begin
          hi_d = prod[2*DWIDTH-1:DWIDTH];
          lo_d = prod[DWIDTH-1:0];
        end else if (rt_q == '0) begin
          hi_d = rs_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort discards everything in flight, including a FIX write
    if (m.m_i_flush && state_q != IDLE) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      opd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      rsg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      opd_q   <= opd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      rsg_q   <= rsg_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu at DWIDTH=32 and DWIDTH=8.
// Expected HI/LO come from plain integer arithmetic on 64-bit values.
module tb_alu_mdu;
  logic clk = 1'b0;
  logic rst;
  logic rst8;
  always #5 clk = ~clk;

  alu_mdu_if #(.DWIDTH(32)) b32();
  alu_mdu_if #(.DWIDTH(8))  b8();

  alu_mdu #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .m(b32.slave)
  );
  alu_mdu #(.DWIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .m(b8.slave)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          t;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32;
  exp_t e8;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [31:0] mhi32 = 0, mlo32 = 0;
  logic [31:0] mhi8 = 0, mlo8 = 0;
  bit done8 = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit [63:0] model(int w, bit [2:0] op,
                                      bit [31:0] rs, bit [31:0] rt);
    longint mk, h, a, b, sa, sb, p, q, r;
    mk = (longint'(1) << w) - 1;
    h  = longint'(1) << (w - 1);
    a  = longint'(rs) & mk;
    b  = longint'(rt) & mk;
    sa = (a ^ h) - h;
    sb = (b ^ h) - h;
    if (op < 2) begin
      p = (op == 0) ? sa * sb : a * b;
      r = (p >> w) & mk;
      q = p & mk;
    end else if (b == 0) begin
      q = mk;
      r = a;
    end else if (op == 2) begin
      q = (sa / sb) & mk;
      r = (sa % sb) & mk;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {32'(r), 32'(q)};
  endfunction

  function automatic bit [31:0] pick(int w);
    bit [31:0] mk;
    bit [31:0] v;
    mk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    case ($urandom_range(0, 7))
      0: v = 0;
      1: v = mk;
      2: v = 32'd1 << (w - 1);
      3: v = $urandom_range(1, 9);
      default: v = $urandom & mk;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    if (b32.m_o_done === 1'b1) begin
      if (q32.size() == 0) begin
        chk("unexpected_done32", 32'd1, 32'd0);
      end else begin
        e32 = q32.pop_front();
        chk("hi32", b32.m_o_hi, e32.hi);
        chk("lo32", b32.m_o_lo, e32.lo);
        chk("lat32", 32'(cyc - e32.t), 32'd35);
        mhi32 = e32.hi;
        mlo32 = e32.lo;
      end
    end
    if (b8.m_o_done === 1'b1) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        chk("hi8", {24'd0, b8.m_o_hi}, e8.hi);
        chk("lo8", {24'd0, b8.m_o_lo}, e8.lo);
        chk("lat8", 32'(cyc - e8.t), 32'd11);
        mhi8 = e8.hi;
        mlo8 = e8.lo;
      end
    end
  end

  task automatic issue32(bit [2:0] op, bit [31:0] rs,
                         bit [31:0] rt, bit push);
    int n;
    bit [63:0] r;
    b32.m_i_valid = 1'b1;
    b32.m_i_op    = op;
    b32.m_i_rs    = rs;
    b32.m_i_rt    = rt;
    n = 0;
    while (b32.m_o_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout32", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    b32.m_i_valid = 1'b0;
    r = model(32, op, rs, rt);
    if (push && op < 4) q32.push_back('{r[63:32], r[31:0], cyc});
    if (op == 4) mhi32 = rs;
    if (op == 5) mlo32 = rs;
  endtask

  task automatic drain32();
    int n;
    n = 0;
    while ((q32.size() != 0 || b32.m_o_ready !== 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout32", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_done32();
    int n;
    n = 0;
    while (b32.m_o_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("done_timeout32", 32'd0, 32'd1);
  endtask

  // DWIDTH=8 stream: random ops with occasional flushes
  initial begin : run8
    bit [2:0] op;
    bit [31:0] rs, rt;
    bit [63:0] r;
    bit fl;
    int n;
    b8.m_i_valid = 1'b0;
    b8.m_i_op    = '0;
    b8.m_i_rs    = '0;
    b8.m_i_rt    = '0;
    b8.m_i_flush = 1'b0;
    @(negedge clk);
    while (rst8 !== 1'b0) @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      op = 3'($urandom_range(0, 7));
      rs = pick(8);
      rt = pick(8);
      fl = (op < 4) && ($urandom_range(0, 7) == 0);
      b8.m_i_valid = 1'b1;
      b8.m_i_op    = op;
      b8.m_i_rs    = rs[7:0];
      b8.m_i_rt    = rt[7:0];
      n = 0;
      while (b8.m_o_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) chk("ready_timeout8", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      b8.m_i_valid = 1'b0;
      r = model(8, op, rs, rt);
      if (op == 4) mhi8 = rs;
      if (op == 5) mlo8 = rs;
      if (op >= 4) begin
        chk("mt_hi8", {24'd0, b8.m_o_hi}, mhi8);
        chk("mt_lo8", {24'd0, b8.m_o_lo}, mlo8);
      end
      if (fl) begin
        repeat ($urandom_range(0, 10)) @(negedge clk);
        @(negedge clk);
        b8.m_i_flush = 1'b1;
        @(posedge clk);
        #1;
        b8.m_i_flush = 1'b0;
        chk("flush_ready8", {31'd0, b8.m_o_ready}, 32'd1);
        chk("flush_hi8", {24'd0, b8.m_o_hi}, mhi8);
      end else if (op < 4) begin
        q8.push_back('{r[63:32], r[31:0], cyc});
      end
    end
    n = 0;
    while (q8.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout8", 32'd0, 32'd1);
    done8 = 1'b1;
  end

  initial begin : main
    int n;
    rst  = 1'b1;
    rst8 = 1'b1;
    b32.m_i_valid = 1'b0;
    b32.m_i_op    = '0;
    b32.m_i_rs    = '0;
    b32.m_i_rt    = '0;
    b32.m_i_flush = 1'b0;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    rst8 = 1'b0;
    chk("rst_hi", b32.m_o_hi, 32'd0);
    chk("rst_lo", b32.m_o_lo, 32'd0);
    chk("rst_ready", {31'd0, b32.m_o_ready}, 32'd1);
    chk("rst_busy", {31'd0, b32.m_o_busy}, 32'd0);
    chk("rst_done", {31'd0, b32.m_o_done}, 32'd0);

    @(negedge clk);
    issue32(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    n = 0;
    for (int k = 0; k < 100 && b32.m_o_done !== 1'b1; k++) begin
      @(negedge clk);
      if (b32.m_o_busy === 1'b1) n++;
    end
    chk("busy_cycles", 32'(n), 32'd34);
    chk("multu_hi", b32.m_o_hi, 32'hFFFF_FFFE);
    chk("multu_lo", b32.m_o_lo, 32'h0000_0001);
    @(negedge clk);
    chk("done_width", {31'd0, b32.m_o_done}, 32'd0);

    issue32(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
    @(negedge clk);
    issue32(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    @(negedge clk);
    issue32(3'd3, 32'd100, 32'd0, 1'b1);
    @(negedge clk);
    issue32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    drain32();
    chk("ovf_lo", b32.m_o_lo, 32'h8000_0000);
    chk("ovf_hi", b32.m_o_hi, 32'd0);

    issue32(3'd4, 32'h1234, 32'd0, 1'b1);
    chk("mthi", b32.m_o_hi, 32'h1234);
    chk("mthi_busy", {31'd0, b32.m_o_busy}, 32'd0);
    issue32(3'd5, 32'h5678, 32'd0, 1'b1);
    chk("mtlo", b32.m_o_lo, 32'h5678);
    chk("mtlo_hi_kept", b32.m_o_hi, 32'h1234);
    chk("mtlo_busy", {31'd0, b32.m_o_busy}, 32'd0);

    @(negedge clk);
    issue32(3'd1, 32'hDEAD_BEEF, 32'h0123_4567, 1'b1);
    @(negedge clk);
    wait_done32();
    issue32(3'd3, 32'h5678, 32'h1234, 1'b1);
    drain32();

    issue32(3'd6, 32'hAAAA, 32'h5555, 1'b1);
    chk("nop_busy", {31'd0, b32.m_o_busy}, 32'd0);
    chk("nop_hi", b32.m_o_hi, mhi32);
    chk("nop_lo", b32.m_o_lo, mlo32);

    @(negedge clk);
    issue32(3'd3, 32'd10, 32'd3, 1'b0);
    repeat (6) @(negedge clk);
    b32.m_i_flush = 1'b1;
    @(posedge clk);
    #1;
    b32.m_i_flush = 1'b0;
    chk("flush_ready", {31'd0, b32.m_o_ready}, 32'd1);
    chk("flush_busy", {31'd0, b32.m_o_busy}, 32'd0);
    repeat (45) @(negedge clk);
    chk("flush_hi", b32.m_o_hi, mhi32);
    chk("flush_lo", b32.m_o_lo, mlo32);

    issue32(3'd0, 32'h0000_1234, 32'h8765_4321, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mhi32 = 0;
    mlo32 = 0;
    chk("midrst_hi", b32.m_o_hi, 32'd0);
    chk("midrst_lo", b32.m_o_lo, 32'd0);
    chk("midrst_busy", {31'd0, b32.m_o_busy}, 32'd0);
    chk("midrst_ready", {31'd0, b32.m_o_ready}, 32'd1);
    repeat (45) @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      bit [2:0] op;
      op = 3'($urandom_range(0, 7));
      issue32(op, pick(32), pick(32), 1'b1);
      if (op == 4) chk("rnd_mthi", b32.m_o_hi, mhi32);
      if (op == 5) chk("rnd_mtlo", b32.m_o_lo, mlo32);
      @(negedge clk);
    end
    drain32();

    n = 0;
    while (!done8 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!done8) chk("run8_timeout", 32'd0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
